// File: rtl/ultratank_input_pkg.sv
// Shared types and the joystick-to-tread mapping for the Ultra Tank input stage.
package ultratank_input_pkg;

    typedef enum logic [1:0] {REQ_N, REQ_F, REQ_B} tread_req_t;
    typedef enum logic [1:0] {NEU, FWD, BK, DEAD} tread_state_t;

    typedef struct packed {
        tread_req_t left;
        tread_req_t right;
    } tread_pair_t;

    // {U,D,L,R} -> (left, right); turns are made by stopping or reversing one tread.
    function automatic tread_pair_t joy_to_treads(input logic [3:0] udlr);
        tread_pair_t p;
        p = '{left: REQ_N, right: REQ_N};
        case (udlr)
            4'b1000: p = '{left: REQ_F, right: REQ_F};
            4'b1001: p = '{left: REQ_F, right: REQ_N};
            4'b0001: p = '{left: REQ_F, right: REQ_B};
            4'b0101: p = '{left: REQ_B, right: REQ_N};
            4'b0100: p = '{left: REQ_B, right: REQ_B};
            4'b0110: p = '{left: REQ_N, right: REQ_B};
            4'b0010: p = '{left: REQ_B, right: REQ_F};
            4'b1010: p = '{left: REQ_N, right: REQ_F};
            default: p = '{left: REQ_N, right: REQ_N};
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tank_input_cond_tread_fsm.sv
// One tread lever: forward/back/neutral with a forced neutral gap on reversal.
module tread_fsm
    import ultratank_input_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 1200,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  tread_req_t i_req,
    output logic       o_fw_n,
    output logic       o_bk_n
);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);

    tread_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_fw_n;
    logic             r_bk_n;

    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= NEU;
            r_cnt   <= '0;
            r_fw_n  <= 1'b1;
            r_bk_n  <= 1'b1;
        end else begin
            case (r_state)
                NEU: begin
                    if (i_req == REQ_F) begin
                        r_state <= FWD;
                        r_fw_n  <= 1'b0;
                    end else if (i_req == REQ_B) begin
                        r_state <= BK;
                        r_bk_n  <= 1'b0;
                    end
                end
                FWD: begin
                    if (i_req != REQ_F) begin
                        r_state <= (i_req == REQ_B) ? DEAD : NEU;
                        r_cnt   <= '0;
                        r_fw_n  <= 1'b1;
                    end
                end
                BK: begin
                    if (i_req != REQ_B) begin
                        r_state <= (i_req == REQ_F) ? DEAD : NEU;
                        r_cnt   <= '0;
                        r_bk_n  <= 1'b1;
                    end
                end
                DEAD: begin
                    // The gap length is fixed at entry; request changes only pick the exit state.
                    if (r_cnt == DEAD_LAST) begin
                        case (i_req)
                            REQ_F: begin
                                r_state <= FWD;
                                r_fw_n  <= 1'b0;
                            end
                            REQ_B: begin
                                r_state <= BK;
                                r_bk_n  <= 1'b0;
                            end
                            default: r_state <= NEU;
                        endcase
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= NEU;
                    r_fw_n  <= 1'b1;
                    r_bk_n  <= 1'b1;
                end
            endcase
        end
    end

    assign o_fw_n = r_fw_n;
    assign o_bk_n = r_bk_n;

endmodule

// File: rtl/tank_input_cond.sv
// Ultra Tank control conditioning: synchronise and debounce both joysticks,
// map them onto the four tread levers, and stretch the coin button into a pulse.
module tank_input_cond
    import ultratank_input_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 12000,
    parameter int unsigned DEAD_CYCLES = 1200,
    parameter int unsigned COIN_CYCLES = 120000,
    parameter int unsigned CNT_W       = 17
) (
    input  logic       clk_sys,
    input  logic       Reset_n,
    input  logic [3:0] joy1_i,
    input  logic [3:0] joy2_i,
    input  logic       coin_i,
    output logic       JoyW_Fw_n,
    output logic       JoyW_Bk_n,
    output logic       JoyX_Fw_n,
    output logic       JoyX_Bk_n,
    output logic       JoyY_Fw_n,
    output logic       JoyY_Bk_n,
    output logic       JoyZ_Fw_n,
    output logic       JoyZ_Bk_n,
    output logic       Coin_n
);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_PRE   = CNT_W'(DEB_CYCLES - 2);
    localparam logic [CNT_W-1:0] COIN_LAST = CNT_W'(COIN_CYCLES - 1);

    logic [1:0][3:0]       w_joy_in;
    logic [1:0][3:0]       r_joy_s1;
    logic [1:0][3:0]       r_joy_s2;
    logic [1:0][3:0]       r_joy_prev;
    logic [1:0][3:0]       r_joy_acc;
    logic [1:0][CNT_W-1:0] r_deb_cnt;
    tread_pair_t [1:0]     r_req;

    assign w_joy_in = {joy2_i, joy1_i};

    // Whole-vector debounce so diagonals are accepted in one step.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            r_joy_s1   <= '0;
            r_joy_s2   <= '0;
            r_joy_prev <= '0;
            r_joy_acc  <= '0;
            r_deb_cnt  <= '0;
            for (int p = 0; p < 2; p++) begin
                r_req[p] <= '{left: REQ_N, right: REQ_N};
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                r_joy_s1[p]   <= w_joy_in[p];
                r_joy_s2[p]   <= r_joy_s1[p];
                r_joy_prev[p] <= r_joy_s2[p];
                if (r_joy_s2[p] != r_joy_prev[p]) begin
                    r_deb_cnt[p] <= '0;
                end else if (r_deb_cnt[p] != DEB_LAST) begin
                    r_deb_cnt[p] <= r_deb_cnt[p] + CNT_W'(1);
                    if (r_deb_cnt[p] == DEB_PRE) begin
                        r_joy_acc[p] <= r_joy_s2[p];
                    end
                end
                r_req[p] <= joy_to_treads(r_joy_acc[p]);
            end
        end
    end

    logic             r_coin_s1;
    logic             r_coin_s2;
    logic             r_coin_prev;
    logic             r_coin_busy;
    logic             r_coin_n;
    logic [CNT_W-1:0] r_coin_cnt;

    // Coin chain resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk_sys or negedge Reset_n) begin
        if (!Reset_n) begin
            r_coin_s1   <= 1'b1;
            r_coin_s2   <= 1'b1;
            r_coin_prev <= 1'b1;
            r_coin_busy <= 1'b0;
            r_coin_n    <= 1'b1;
            r_coin_cnt  <= '0;
        end else begin
            r_coin_s1   <= coin_i;
            r_coin_s2   <= r_coin_s1;
            r_coin_prev <= r_coin_s2;
            if (r_coin_busy) begin
                if (r_coin_cnt == COIN_LAST) begin
                    r_coin_busy <= 1'b0;
                    r_coin_n    <= 1'b1;
                end else begin
                    r_coin_cnt <= r_coin_cnt + CNT_W'(1);
                end
            end else if (r_coin_s2 && !r_coin_prev) begin
                r_coin_busy <= 1'b1;
                r_coin_n    <= 1'b0;
                r_coin_cnt  <= '0;
            end
        end
    end

    assign Coin_n = r_coin_n;

    tread_fsm #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_tread_w (
        .clk_sys (clk_sys),
        .Reset_n (Reset_n),
        .i_req   (r_req[0].left),
        .o_fw_n  (JoyW_Fw_n),
        .o_bk_n  (JoyW_Bk_n)
    );

    tread_fsm #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_tread_x (
        .clk_sys (clk_sys),
        .Reset_n (Reset_n),
        .i_req   (r_req[0].right),
        .o_fw_n  (JoyX_Fw_n),
        .o_bk_n  (JoyX_Bk_n)
    );

    tread_fsm #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_tread_y (
        .clk_sys (clk_sys),
        .Reset_n (Reset_n),
        .i_req   (r_req[1].left),
        .o_fw_n  (JoyY_Fw_n),
        .o_bk_n  (JoyY_Bk_n)
    );

    tread_fsm #(.DEAD_CYCLES(DEAD_CYCLES), .CNT_W(CNT_W)) u_tread_z (
        .clk_sys (clk_sys),
        .Reset_n (Reset_n),
        .i_req   (r_req[1].right),
        .o_fw_n  (JoyZ_Fw_n),
        .o_bk_n  (JoyZ_Bk_n)
    );

endmodule

// File: tb/tb_tank_input_cond.sv
// Scoreboard bench for tank_input_cond: a slow-debounce and a fast-debounce
// instance share stimulus and are checked against one behavioural model.
module tb_tank_input_cond;
    localparam int DEB_S = 8;
    localparam int DEB_F = 2;
    localparam int DEAD  = 4;
    localparam int COIN  = 6;
    localparam int HLEN  = DEB_S + 2;

    logic       clk_sys = 1'b0;
    logic       Reset_n = 1'b0;
    logic [3:0] joy1_i  = 4'b0000;
    logic [3:0] joy2_i  = 4'b0000;
    logic       coin_i  = 1'b0;

    logic [8:0] act_s;
    logic [8:0] act_f;

    tank_input_cond #(.DEB_CYCLES(DEB_S), .DEAD_CYCLES(DEAD), .COIN_CYCLES(COIN), .CNT_W(17)) dut_slow (
        .clk_sys   (clk_sys),
        .Reset_n   (Reset_n),
        .joy1_i    (joy1_i),
        .joy2_i    (joy2_i),
        .coin_i    (coin_i),
        .JoyW_Fw_n (act_s[8]),
        .JoyW_Bk_n (act_s[7]),
        .JoyX_Fw_n (act_s[6]),
        .JoyX_Bk_n (act_s[5]),
        .JoyY_Fw_n (act_s[4]),
        .JoyY_Bk_n (act_s[3]),
        .JoyZ_Fw_n (act_s[2]),
        .JoyZ_Bk_n (act_s[1]),
        .Coin_n    (act_s[0])
    );

    tank_input_cond #(.DEB_CYCLES(DEB_F), .DEAD_CYCLES(DEAD), .COIN_CYCLES(COIN), .CNT_W(17)) dut_fast (
        .clk_sys   (clk_sys),
        .Reset_n   (Reset_n),
        .joy1_i    (joy1_i),
        .joy2_i    (joy2_i),
        .coin_i    (coin_i),
        .JoyW_Fw_n (act_f[8]),
        .JoyW_Bk_n (act_f[7]),
        .JoyX_Fw_n (act_f[6]),
        .JoyX_Bk_n (act_f[5]),
        .JoyY_Fw_n (act_f[4]),
        .JoyY_Bk_n (act_f[3]),
        .JoyZ_Fw_n (act_f[2]),
        .JoyZ_Bk_n (act_f[1]),
        .Coin_n    (act_f[0])
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_err = 0;
    logic [17:0] exp_q [$];

    // Model state. Tread/request encoding: 0 neutral, 1 forward, 2 back, 3 dead gap.
    logic [3:0] hj [2][HLEN];     // per-player pin history, [0] = value for the coming edge
    logic       hc [4];
    logic [3:0] m_acc [2][2];     // [instance][player]
    int         m_req [2][4];     // [instance][lever W,X,Y,Z]
    int         m_st  [2][4];
    int         m_rem [2][4];
    int         c_rem;
    int         debs [2] = '{DEB_S, DEB_F};

    task automatic map_req(input logic [3:0] v, output int l, output int r);
        case (v)
            4'b1000: begin l = 1; r = 1; end
            4'b1001: begin l = 1; r = 0; end
            4'b0001: begin l = 1; r = 2; end
            4'b0101: begin l = 2; r = 0; end
            4'b0100: begin l = 2; r = 2; end
            4'b0110: begin l = 0; r = 2; end
            4'b0010: begin l = 2; r = 1; end
            4'b1010: begin l = 0; r = 1; end
            default: begin l = 0; r = 0; end
        endcase
    endtask

    task automatic tread_step(input int i, input int t);
        int r;
        r = m_req[i][t];
        case (m_st[i][t])
            0: if (r != 0) m_st[i][t] = r;
            1, 2: begin
                if (r == 0) m_st[i][t] = 0;
                else if (r != m_st[i][t]) begin
                    m_st[i][t]  = 3;
                    m_rem[i][t] = DEAD;
                end
            end
            default: begin
                if (m_rem[i][t] == 1) m_st[i][t] = r;
                else m_rem[i][t] = m_rem[i][t] - 1;
            end
        endcase
    endtask

    function automatic bit window_stable(input int p, input int d);
        for (int k = 3; k <= d + 1; k++) begin
            if (hj[p][k] != hj[p][2]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model across the next rising edge and queue the outputs it predicts.
    task automatic model_step(input bit rst);
        logic [17:0] e;
        int l, r;
        if (rst) begin
            for (int p = 0; p < 2; p++)
                for (int k = 0; k < HLEN; k++) hj[p][k] = 4'b0000;
            for (int k = 0; k < 4; k++) hc[k] = 1'b1;
            for (int i = 0; i < 2; i++) begin
                m_acc[i][0] = 4'b0000;
                m_acc[i][1] = 4'b0000;
                for (int t = 0; t < 4; t++) begin
                    m_req[i][t] = 0;
                    m_st[i][t]  = 0;
                    m_rem[i][t] = 0;
                end
            end
            c_rem = 0;
        end else begin
            for (int k = HLEN - 1; k > 0; k--) begin
                hj[0][k] = hj[0][k-1];
                hj[1][k] = hj[1][k-1];
            end
            for (int k = 3; k > 0; k--) hc[k] = hc[k-1];
            hj[0][0] = joy1_i;
            hj[1][0] = joy2_i;
            hc[0]    = coin_i;
            for (int i = 0; i < 2; i++) begin
                for (int t = 0; t < 4; t++) tread_step(i, t);
                for (int p = 0; p < 2; p++) begin
                    map_req(m_acc[i][p], l, r);
                    m_req[i][2*p]   = l;
                    m_req[i][2*p+1] = r;
                end
                for (int p = 0; p < 2; p++)
                    if (window_stable(p, debs[i])) m_acc[i][p] = hj[p][2];
            end
            if (c_rem > 0) c_rem = c_rem - 1;
            else if (hc[2] && !hc[3]) c_rem = COIN;
        end
        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 4; t++) begin
                e[i*9 + 8 - 2*t] = (m_st[i][t] != 1);
                e[i*9 + 7 - 2*t] = (m_st[i][t] != 2);
            end
            e[i*9] = !(c_rem > 0);
        end
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t: got WXYZ/coin=%b, expected %b", name, $time, act, exp_v);
        end
    endtask

    initial begin
        logic [17:0] e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("slow", act_s, e[8:0]);
                chk("fast", act_f, e[17:9]);
            end
        end
    end

    task automatic seg(input logic [3:0] j1, input logic [3:0] j2, input logic c, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_sys);
            Reset_n = 1'b1;
            joy1_i  = j1;
            joy2_i  = j2;
            coin_i  = c;
            model_step(1'b0);
        end
    endtask

    task automatic rst_seg(input int n, input logic c);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_sys);
            Reset_n = 1'b0;
            joy1_i  = 4'b0000;
            joy2_i  = 4'b0000;
            coin_i  = c;
            model_step(1'b1);
        end
    endtask

    task automatic async_rst();
        @(posedge clk_sys);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("async_reset_slow", act_s, 9'h1FF);
        chk("async_reset_fast", act_f, 9'h1FF);
    endtask

    logic [3:0] codes [12] = '{4'b0000, 4'b1000, 4'b1001, 4'b0001, 4'b0101, 4'b0100,
                               4'b0110, 4'b0010, 4'b1010, 4'b1100, 4'b0011, 4'b1111};

    initial begin
        logic [3:0] j1, j2;
        logic       c;
        int         n, w;
        rst_seg(3, 1'b0);
        seg(4'b1000, 4'b0000, 1'b0, 20);
        seg(4'b0000, 4'b0000, 1'b0, 16);
        seg(4'b1000, 4'b0000, 1'b0, 5);
        seg(4'b0000, 4'b0000, 1'b0, 16);
        seg(4'b1000, 4'b0000, 1'b0, 20);
        seg(4'b0100, 4'b0000, 1'b0, 25);
        seg(4'b1000, 4'b0000, 1'b0, 20);
        seg(4'b0100, 4'b0000, 1'b0, 3);
        seg(4'b1000, 4'b0000, 1'b0, 25);
        seg(4'b0000, 4'b0000, 1'b1, 20);
        seg(4'b0000, 4'b0000, 1'b0, 10);
        seg(4'b0000, 4'b0000, 1'b1, 4);
        seg(4'b0000, 4'b0000, 1'b0, 12);
        seg(4'b0000, 4'b0000, 1'b1, 5);
        rst_seg(3, 1'b1);
        seg(4'b0000, 4'b0000, 1'b1, 15);
        seg(4'b0000, 4'b0000, 1'b0, 5);
        seg(4'b1000, 4'b0000, 1'b0, 20);
        seg(4'b0100, 4'b0000, 1'b0, 8);
        seg(4'b0100, 4'b0000, 1'b1, 4);
        async_rst();
        rst_seg(2, 1'b0);
        seg(4'b0000, 4'b0110, 1'b0, 20);
        for (int s = 0; s < 160; s++) begin
            j1 = codes[$urandom_range(0, 11)];
            j2 = codes[$urandom_range(0, 11)];
            c  = 1'($urandom_range(0, 1));
            n  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(8, 24));
            if ($urandom_range(0, 29) == 0) begin
                async_rst();
                rst_seg(int'($urandom_range(1, 3)), c);
            end
            seg(j1, j2, c, n);
        end
        seg(4'b0000, 4'b0000, 1'b0, 10);
        w = 0;
        while (exp_q.size() > 0 && w < 5) begin
            @(posedge clk_sys);
            #2;
            w++;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
